// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control sequencer for a simple CPU datapath. Walks each
//   instruction through FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK and
//   loops back to FETCH. A taken halt parks the FSM in HALT. A data-memory
//   access that never completes parks it in ERROR. Only reset leaves either
//   state.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   MEM_TIMEOUT  MEMORY cycles allowed without mem_ready before a fault
//
// Ports
//   clock, reset         rising-edge clock; asynchronous active-high reset
//   start                leave IDLE (sampled only in IDLE)
//   type_code[1:0]       00 memory, 01 data-processing, 10 branch, 11 halt
//   load_bit             0 = memory read into Rd, 1 = write Rh to memory
//   should_store_link    branch also writes the link register
//   set_cond_bit         instruction updates flags
//   write_condition      condition field passed
//   mem_ready            data memory access complete
//   ir_enable .. cpsr_write  datapath strobes, combinational from state+inputs
//   busy/halted/mem_error    status, decoded from state
//   state[2:0]           current FSM state code
//   retired_count        instructions completed, wraps silently
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       type_code,
  input  logic             load_bit,
  input  logic             should_store_link,
  input  logic             set_cond_bit,
  input  logic             write_condition,
  input  logic             mem_ready,
  output logic             ir_enable,
  output logic             pc_enable,
  output logic             reg_write,
  output logic             link_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             cpsr_write,
  output logic             busy,
  output logic             halted,
  output logic             mem_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  // The wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] T_MEM    = 2'b00;
  localparam logic [1:0] T_DP     = 2'b01;
  localparam logic [1:0] T_BRANCH = 2'b10;
  localparam logic [1:0] T_HALT   = 2'b11;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_cnt      <= '0;
      retired_count <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (type_code == T_HALT && write_condition) state_q <= S_HALT;
          else                                        state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          // Only a passed memory instruction touches data memory.
          if (write_condition && type_code == T_MEM) begin
            state_q  <= S_MEMORY;
            wait_cnt <= '0;
          end else begin
            state_q  <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          // mem_ready is tested first so a completion on the last allowed
          // cycle still retires the instruction.
          if (mem_ready)                  state_q <= S_WRITEBACK;
          else if (wait_cnt == WAIT_LAST) state_q <= S_ERROR;
          else                            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_WRITEBACK: begin
          retired_count <= retired_count + CNT_W'(1);
          state_q       <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state register, so an asynchronous reset
  // drops them immediately without waiting for a clock edge.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    ir_enable  = 1'b0;
    pc_enable  = 1'b0;
    reg_write  = 1'b0;
    link_write = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    cpsr_write = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    mem_error  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        busy      = 1'b1;
        ir_enable = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXECUTE: begin
        busy       = 1'b1;
        cpsr_write = set_cond_bit & write_condition;
      end
      S_MEMORY: begin
        busy      = 1'b1;
        mem_read  = ~load_bit;
        mem_write = load_bit;
      end
      S_WRITEBACK: begin
        busy       = 1'b1;
        pc_enable  = 1'b1;
        reg_write  = write_condition &
                     ((type_code == T_DP) || (type_code == T_MEM && !load_bit));
        link_write = write_condition & (type_code == T_BRANCH) & should_store_link;
      end
      S_HALT:  halted    = 1'b1;
      S_ERROR: mem_error = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//   Self-checking bench for cpu_sequencer, built with CNT_W=4 so counter wrap
//   is reachable. For each instruction the bench derives the expected cycle
//   list (state code, strobes, status, retired count) from the instruction
//   fields and the memory-ready delay. It then compares the DUT every cycle,
//   one time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM   = 3'd4, ST_WB     = 3'd5,
                         ST_HALT = 3'd6, ST_ERR   = 3'd7;

  // Strobe vector order: {ir, pc, reg, link, mem_read, mem_write, cpsr}
  localparam logic [6:0] IR = 7'b1000000, PC = 7'b0100000, RW = 7'b0010000,
                         LW = 7'b0001000, MR = 7'b0000100, MW = 7'b0000010,
                         CP = 7'b0000001, NONE = 7'b0000000;
  // Status vector order: {busy, halted, mem_error}
  localparam logic [2:0] BUSY = 3'b100, HALTED = 3'b010, MERR = 3'b001,
                         QUIET = 3'b000;

  logic clock = 1'b0;
  logic reset, start, load_bit, should_store_link, set_cond_bit;
  logic write_condition, mem_ready;
  logic [1:0] type_code;
  logic ir_enable, pc_enable, reg_write, link_write, mem_read, mem_write;
  logic cpsr_write, busy, halted, mem_error;
  logic [2:0] state;
  logic [CNT_W-1:0] retired_count;

  cpu_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .type_code(type_code),
    .load_bit(load_bit), .should_store_link(should_store_link),
    .set_cond_bit(set_cond_bit), .write_condition(write_condition),
    .mem_ready(mem_ready), .ir_enable(ir_enable), .pc_enable(pc_enable),
    .reg_write(reg_write), .link_write(link_write), .mem_read(mem_read),
    .mem_write(mem_write), .cpsr_write(cpsr_write), .busy(busy),
    .halted(halted), .mem_error(mem_error), .state(state),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int exp_count = 0;   // instructions retired since the last reset

  // Fields of the instruction currently being sequenced.
  logic [1:0] i_type;
  logic       i_load, i_link, i_setc, i_cond;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] count_mod();
    return 32'(exp_count % (1 << CNT_W));
  endfunction

  // One clock cycle: drive inputs after the falling edge, then compare.
  task automatic cyc(input bit apply, input logic [2:0] st, input logic [6:0] stb,
                     input logic [2:0] sts, input logic mr, input logic go);
    @(negedge clock);
    if (apply) begin
      type_code         = i_type;
      load_bit          = i_load;
      should_store_link = i_link;
      set_cond_bit      = i_setc;
      write_condition   = i_cond;
    end
    mem_ready = mr;
    start     = go;
    #1;
    check("state",   32'(state), 32'(st));
    check("strobes", 32'({ir_enable, pc_enable, reg_write, link_write,
                          mem_read, mem_write, cpsr_write}), 32'(stb));
    check("status",  32'({busy, halted, mem_error}), 32'(sts));
    check("count",   32'(retired_count), count_mod());
  endtask

  // Reset, confirm the reset state, wait idle, then pulse start in IDLE.
  task automatic reset_and_start();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    #1;
    exp_count = 0;
    check("rst_state",   32'(state), 32'(ST_IDLE));
    check("rst_strobes", 32'({ir_enable, pc_enable, reg_write, link_write,
                              mem_read, mem_write, cpsr_write}), 32'(NONE));
    check("rst_status",  32'({busy, halted, mem_error}), 32'(QUIET));
    check("rst_count",   32'(retired_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc(0, ST_IDLE, NONE, QUIET, 0, 0);
    cyc(0, ST_IDLE, NONE, QUIET, 0, 0);
    cyc(0, ST_IDLE, NONE, QUIET, 0, 1);
  endtask

  // Expected walk of one instruction, starting from its FETCH cycle.
  // ready_at = MEMORY cycle (1-based) where mem_ready is driven; out of
  // 1..MEM_TIMEOUT means never. parked=1 when the FSM ends in HALT/ERROR.
  task automatic run_instr(input logic [1:0] t, input logic ld, input logic lk,
                           input logic sc, input logic cd, input int ready_at,
                           output bit parked);
    logic [6:0] wb;
    i_type = t; i_load = ld; i_link = lk; i_setc = sc; i_cond = cd;
    parked = 1'b0;
    cyc(1, ST_FETCH,  IR,   BUSY, 0, 0);
    cyc(0, ST_DECODE, NONE, BUSY, 0, 0);
    if (t == 2'b11 && cd) begin
      cyc(0, ST_HALT, NONE, HALTED, 0, 0);
      parked = 1'b1;
      return;
    end
    cyc(0, ST_EXEC, (sc && cd) ? CP : NONE, BUSY, 0, 0);
    if (cd && t == 2'b00) begin
      for (int i = 1; i <= MEM_TIMEOUT; i++) begin
        cyc(0, ST_MEM, ld ? MW : MR, BUSY, logic'(i == ready_at), 0);
        if (i == ready_at) break;
      end
      if (ready_at < 1 || ready_at > MEM_TIMEOUT) begin
        cyc(0, ST_ERR, NONE, MERR, 0, 0);
        parked = 1'b1;
        return;
      end
    end
    wb = PC;
    if (cd && (t == 2'b01 || (t == 2'b00 && !ld))) wb = wb | RW;
    if (cd && t == 2'b10 && lk)                     wb = wb | LW;
    cyc(0, ST_WB, wb, BUSY, 0, 0);
    exp_count++;
  endtask

  initial begin
    bit parked;
    reset = 1'b1; start = 1'b0; type_code = 2'b00; load_bit = 1'b0;
    should_store_link = 1'b0; set_cond_bit = 1'b0; write_condition = 1'b0;
    mem_ready = 1'b0;

    // Directed instructions, including ready on the final allowed cycle.
    reset_and_start();
    run_instr(2'b01, 0, 0, 1, 1, 0, parked);                 // ALU, flags set
    run_instr(2'b00, 0, 0, 0, 1, 3, parked);                 // load, ready on 3rd
    run_instr(2'b10, 0, 1, 1, 0, 0, parked);                 // branch, cond fails
    run_instr(2'b10, 0, 1, 0, 1, 0, parked);                 // branch with link
    run_instr(2'b00, 1, 0, 0, 1, MEM_TIMEOUT, parked);       // store, ready at limit
    run_instr(2'b11, 0, 0, 0, 0, 0, parked);                 // halt, cond fails
    run_instr(2'b00, 0, 0, 1, 0, 0, parked);                 // memory, cond fails

    // Randomized instruction mix; the counter wraps several times.
    for (int n = 0; n < 40; n++) begin
      run_instr(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                logic'($urandom_range(0, 3) != 0), int'($urandom_range(1, 6)),
                parked);
    end

    // Sixteen ALU instructions from reset bring a 4-bit counter back to 0.
    reset_and_start();
    for (int n = 0; n < 16; n++) run_instr(2'b01, 0, 0, 0, 1, 0, parked);
    #5;
    check("wrap16", 32'(retired_count), 32'd0);

    // Store that never completes: MEM_TIMEOUT write cycles, then ERROR.
    run_instr(2'b00, 1, 0, 0, 1, 0, parked);
    check("err_parked", 32'(parked), 32'd1);
    for (int n = 0; n < 3; n++) cyc(0, ST_ERR, NONE, MERR, 0, 1);

    // Halt: parks in HALT, count frozen, start pulses ignored.
    reset_and_start();
    run_instr(2'b01, 0, 0, 0, 1, 0, parked);
    run_instr(2'b11, 0, 0, 0, 1, 0, parked);
    check("halt_parked", 32'(parked), 32'd1);
    for (int n = 0; n < 4; n++) cyc(0, ST_HALT, NONE, HALTED, 0, logic'(n % 2 == 0));

    // Reset in the middle of a load drops mem_read before any clock edge.
    reset_and_start();
    i_type = 2'b00; i_load = 1'b0; i_link = 1'b0; i_setc = 1'b0; i_cond = 1'b1;
    cyc(1, ST_FETCH,  IR,   BUSY, 0, 0);
    cyc(0, ST_DECODE, NONE, BUSY, 0, 0);
    cyc(0, ST_EXEC,   NONE, BUSY, 0, 0);
    cyc(0, ST_MEM,    MR,   BUSY, 0, 0);
    #1 reset = 1'b1;
    #1;
    check("async_mem_read", 32'(mem_read), 32'd0);
    check("async_state",    32'(state),    32'(ST_IDLE));
    check("async_busy",     32'(busy),     32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
    for (int n = 0; n < 3; n++) cyc(0, ST_IDLE, NONE, QUIET, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
